// File: rtl/layer_3_collector.sv
// Third conv layer output reader: captures 16-channel vectors into a 2-entry buffer
// with optional ReLU and serialises them one channel per valid/ready transfer.
module layer_3_collector #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned CH_NUM        = 16,
    parameter int unsigned PIX_PER_FRAME = 64,
    parameter int unsigned RELU_EN       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic [WORD_SIZE*CH_NUM-1:0] i_data,
    input  logic                        i_valid,
    output logic                        o_in_ready,
    output logic [WORD_SIZE-1:0]        o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last,
    output logic                        o_overflow
);

    localparam int unsigned CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned PW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] slot_q [2][CH_NUM];
    logic [WORD_SIZE-1:0] slot_d [2][CH_NUM];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [CW-1:0]        ch_cnt_q, ch_cnt_d;
    logic [PW-1:0]        pix_cnt_q, pix_cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 last_q, last_d;

    logic                 push;
    logic                 drop;
    logic                 pop_word;
    logic                 pop_vec;
    logic [WORD_SIZE-1:0] word;

    // Next-state: buffer, counters, serialiser FSM and registered stream outputs
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        ch_cnt_d   = ch_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        ovf_d      = ovf_q;
        data_d     = '0;
        last_d     = 1'b0;
        word       = '0;

        push     = i_valid && (cnt_q != 2'd2);
        drop     = i_valid && (cnt_q == 2'd2);
        pop_word = (state_q == ST_SEND) && i_ready;
        pop_vec  = pop_word && (ch_cnt_q == CW'(CH_NUM - 1));

        if (push) begin
            for (int k = 0; k < int'(CH_NUM); k++) begin
                word = i_data[k*WORD_SIZE +: WORD_SIZE];
                if ((RELU_EN != 0) && word[WORD_SIZE-1]) begin
                    word = '0;
                end
                slot_d[wr_ptr_q][k] = word;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (pop_word) begin
            ch_cnt_d = pop_vec ? '0 : ch_cnt_q + CW'(1);
        end
        if (pop_vec) begin
            rd_ptr_d  = ~rd_ptr_q;
            pix_cnt_d = (pix_cnt_q == PW'(PIX_PER_FRAME - 1)) ? '0 : pix_cnt_q + PW'(1);
        end

        case ({push, pop_vec})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Clear takes priority over a same-cycle drop
        if (i_clr) begin
            pix_cnt_d = '0;
            ovf_d     = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: if (cnt_q != 2'd0) state_d = ST_SEND;
            ST_SEND: if (pop_vec && (cnt_d == 2'd0)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // slot_d already holds a same-cycle capture, so back-to-back vectors need no bubble
        if (state_d == ST_SEND) begin
            data_d = slot_d[rd_ptr_d][ch_cnt_d];
            last_d = (ch_cnt_d == CW'(CH_NUM - 1)) && (pix_cnt_d == PW'(PIX_PER_FRAME - 1));
        end

        in_ready_d = (cnt_d != 2'd2);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < int'(CH_NUM); k++) begin
                    slot_q[s][k] <= '0;
                end
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            ch_cnt_q   <= '0;
            pix_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ch_cnt_q   <= ch_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

    assign o_valid    = (state_q == ST_SEND);
    assign o_data     = data_q;
    assign o_last     = last_q;
    assign o_overflow = ovf_q;
    assign o_in_ready = in_ready_q;

endmodule

// File: tb/tb_layer_3_collector.sv
// Bench for layer_3_collector: two instances (ReLU on/off, 4-pixel frames) driven in
// lockstep and compared against a queue-based model of the collector's stream.
module tb_layer_3_collector;

    localparam int W   = 16;
    localparam int CH  = 16;
    localparam int PIX = 4;

    logic            clk;
    logic            rst;
    logic            i_clr;
    logic [W*CH-1:0] i_data;
    logic            i_valid;
    logic            i_ready;

    logic          a_in_ready, a_valid, a_last, a_ovf;
    logic [W-1:0]  a_data;
    logic          b_in_ready, b_valid, b_last, b_ovf;
    logic [W-1:0]  b_data;

    layer_3_collector #(.WORD_SIZE(W), .CH_NUM(CH), .PIX_PER_FRAME(PIX), .RELU_EN(1)) u_a (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_data(i_data), .i_valid(i_valid),
        .o_in_ready(a_in_ready), .o_data(a_data), .o_valid(a_valid), .i_ready(i_ready),
        .o_last(a_last), .o_overflow(a_ovf)
    );

    layer_3_collector #(.WORD_SIZE(W), .CH_NUM(CH), .PIX_PER_FRAME(PIX), .RELU_EN(0)) u_b (
        .clk(clk), .rst(rst), .i_clr(i_clr), .i_data(i_data), .i_valid(i_valid),
        .o_in_ready(b_in_ready), .o_data(b_data), .o_valid(b_valid), .i_ready(i_ready),
        .o_last(b_last), .o_overflow(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int nlast = 0;

    // Model: queue of pending raw words (bit 16 marks a vector's final channel)
    logic [16:0] mq[$];
    int          mcnt;
    int          mpix;
    bit          mvalid;
    bit          movf;

    function automatic logic [15:0] relu(input logic [15:0] w);
        return ($signed(w) < 0) ? 16'h0000 : w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcnt   = 0;
        mpix   = 0;
        mvalid = 1'b0;
        movf   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        bit          had_vec;
        bit          acc;
        logic [16:0] e;
        had_vec = (mcnt != 0);
        acc     = i_valid && (mcnt < 2);
        if (mvalid && i_ready) begin
            e = mq.pop_front();
            if (e[16]) begin
                mcnt--;
                mpix = (mpix == PIX - 1) ? 0 : mpix + 1;
            end
        end
        if (acc) begin
            for (int k = 0; k < CH; k++) mq.push_back({k == CH - 1, i_data[k*W +: W]});
            mcnt++;
        end
        if (i_clr) begin
            mpix = 0;
            movf = 1'b0;
        end else if (i_valid && !acc) begin
            movf = 1'b1;
        end
        mvalid = mvalid ? (mcnt != 0) : had_vec;
    endtask

    task automatic check_all();
        logic exp_last;
        chk("a_valid", 32'(a_valid), 32'(mvalid));
        chk("b_valid", 32'(b_valid), 32'(mvalid));
        chk("a_in_ready", 32'(a_in_ready), 32'(mcnt != 2));
        chk("b_in_ready", 32'(b_in_ready), 32'(mcnt != 2));
        chk("a_overflow", 32'(a_ovf), 32'(movf));
        chk("b_overflow", 32'(b_ovf), 32'(movf));
        if (mvalid) begin
            exp_last = mq[0][16] && (mpix == PIX - 1);
            chk("a_data", 32'(a_data), 32'(relu(mq[0][15:0])));
            chk("b_data", 32'(b_data), 32'(mq[0][15:0]));
        end else begin
            exp_last = 1'b0;
        end
        chk("a_last", 32'(a_last), 32'(exp_last));
        chk("b_last", 32'(b_last), 32'(exp_last));
        if (a_valid && a_last) nlast++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [W*CH-1:0] d);
        i_data  = d;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int i = 0; i < 120 && (mvalid || mcnt != 0); i++) tick();
        tick();
        chk("drain_idle", 32'(a_valid), 32'(0));
    endtask

    function automatic logic [W*CH-1:0] rand_vec();
        logic [W*CH-1:0] v;
        for (int k = 0; k < CH; k++) v[k*W +: W] = 16'($urandom);
        return v;
    endfunction

    logic [W*CH-1:0] v;
    bit              pat [4];

    initial begin
        rst     = 1'b0;
        i_clr   = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_valid), 32'(0));
        chk("rst_data", 32'(a_data), 32'(0));
        chk("rst_last", 32'(a_last), 32'(0));
        chk("rst_ovf", 32'(a_ovf), 32'(0));
        chk("rst_in_ready", 32'(a_in_ready), 32'(1));
        check_all();
        rst = 1'b0;
        tick();

        // T1: channel k carries k+1, continuous ready
        for (int k = 0; k < CH; k++) v[k*W +: W] = 16'(k + 1);
        i_ready = 1'b1;
        send(v);
        drain();

        // T2: ReLU boundary words
        v = rand_vec();
        v[3*W +: W] = 16'h8005;
        v[4*W +: W] = 16'h7FFF;
        send(v);
        drain();

        // T3: ready pattern 1,0,0,1 with random vector arrivals and clears
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            i_ready = pat[c % 4];
            i_clr   = ($urandom % 40) == 0;
            if (($urandom % 6) == 0) begin
                i_data  = rand_vec();
                i_valid = 1'b1;
            end
            tick();
            i_valid = 1'b0;
            i_clr   = 1'b0;
        end
        drain();

        // T4: overflow with stalled downstream, then clear
        i_ready = 1'b0;
        send(rand_vec());
        send(rand_vec());
        chk("t4_full", 32'(a_in_ready), 32'(0));
        send(rand_vec());
        chk("t4_ovf", 32'(a_ovf), 32'(1));
        tick();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("t4_ovf_clr", 32'(a_ovf), 32'(0));
        drain();

        // T5: frame wrap across five vectors
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        nlast = 0;
        for (int p = 0; p < 5; p++) begin
            send(rand_vec());
            for (int i = 0; i < 15; i++) tick();
        end
        drain();
        chk("t5_last_count", 32'(nlast), 32'(1));

        // T6: asynchronous reset at word 7 of a vector
        send(rand_vec());
        for (int i = 0; i < 40 && !(mvalid && mq.size() == CH - 6); i++) tick();
        chk("t6_at_word7", 32'(a_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(a_valid), 32'(0));
        chk("t6_data", 32'(a_data), 32'(0));
        chk("t6_in_ready", 32'(a_in_ready), 32'(1));
        chk("t6_b_valid", 32'(b_valid), 32'(0));
        chk("t6_b_data", 32'(b_data), 32'(0));
        model_reset();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        send(rand_vec());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
